omsp_spm_key_loader: RTL
========================

OMSP_SPM_KEY_LOADER -- requirements
Module: omsp_spm_key_loader

Interface
REQ-001 SHALL have parameter KEY_WORDS, default 4, giving the number of 16-bit key words per module key (4 = 64-bit SECURITY).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, giving the source stall limit; 8-bit counter.
REQ-003 mclk  in  1  sole clock; all state on rising edge.
REQ-004 puc_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 start  in  1  one-cycle request to load a key into module start_id.
REQ-006 start_id  in  16  target protected-module ID.
REQ-007 abort  in  1  cancel the load in progress.
REQ-008 key_select_valid  in  1  module array reports that spm_key_select matches an enabled module.
REQ-009 src_valid  in  1  key source has a word.
REQ-010 src_data  in  16  key word, most significant word first.
REQ-011 src_ready  out  1  loader accepts a word this cycle.
REQ-012 spm_key_select  out  16  module ID driven to the array.
REQ-013 write_key  out  1  one-cycle key-word write strobe to the array.
REQ-014 key_in  out  16  key word accompanying write_key.
REQ-015 busy  out  1  high in any state other than IDLE.
REQ-016 done  out  1  one-cycle success pulse.
REQ-017 error  out  1  sticky failure flag; cleared by the next accepted start.

Function
REQ-018 FSM states: IDLE, CHECK, LOAD, FLUSH, DONE; state register is binary-encoded.
REQ-019 IDLE: start=1 with start_id!=0 -> latch start_id into spm_key_select, clear error and word count, -> CHECK.
REQ-020 IDLE: start=1 with start_id==0 -> set error, stay IDLE, no done pulse.
REQ-021 CHECK (exactly one cycle): key_select_valid=1 -> LOAD; key_select_valid=0 -> set error, -> IDLE.
REQ-022 LOAD: src_ready=1; a word is accepted when src_valid&src_ready, and the word count increments.
REQ-023 Accepted word SHALL be registered: key_in=src_data and write_key=1 in the following cycle (latency 1).
REQ-024 On acceptance of word KEY_WORDS-1 (0-based) -> FLUSH, with src_ready=0 from that next cycle.
REQ-025 FLUSH: last write_key strobe issues -> DONE; DONE: done=1 for one cycle -> IDLE.
REQ-026 spm_key_select SHALL hold the latched ID from CHECK through DONE and read 16'h0 in IDLE.
REQ-027 key_in SHALL hold its last value when write_key=0.
REQ-028 start while busy=1 SHALL be ignored, with no effect on state, ID or error.
REQ-029 abort=1 in any busy state -> IDLE next cycle, error=1, no done pulse, and no write_key after the abort cycle.
REQ-030 abort in the same cycle as a word acceptance: the word is discarded and abort wins.
REQ-031 abort in IDLE SHALL have no effect.
REQ-032 Word counter width SHALL be clog2(KEY_WORDS)+1 bits, and the counter never wraps within a load.
REQ-033 Exactly KEY_WORDS write_key strobes SHALL be issued per successful load.

Reset
REQ-034 On puc_rst_n=0: state=IDLE, spm_key_select=0, key_in=0, write_key=0, src_ready=0, busy=0, done=0, error=0, counters=0.
REQ-035 Reset mid-load SHALL drop the load with no further strobes; error reads 0 after reset.

Configuration
REQ-036 Macro SPM_KEY_TIMEOUT_EN defined: in LOAD, a stall counter increments each cycle without acceptance and resets on acceptance.
REQ-037 With SPM_KEY_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES -> IDLE, error=1, no done.
REQ-038 SPM_KEY_TIMEOUT_EN undefined: no stall counter is present, and LOAD waits indefinitely.

Verification
REQ-039 Scenario: start, id=16'h0003, valid=1 in CHECK, src words 1111,2222,3333,4444 back-to-back -> 4 write_key strobes with those key_in values on consecutive cycles, done 1 cycle after the last strobe, error=0.
REQ-040 Scenario: start, id=16'h0005, key_select_valid=0 -> CHECK->IDLE, error=1, write_key never asserted.
REQ-041 Scenario: start, id=16'h0000 -> error=1 next cycle, busy stays 0.
REQ-042 Scenario: abort in the cycle word 2 is accepted -> exactly 2 strobes total, error=1, spm_key_select=0 next cycle.
REQ-043 Scenario: second start, id=7, during a load of id=3 -> ignored; all strobes carry spm_key_select=3.
REQ-044 Scenario: with SPM_KEY_TIMEOUT_EN, TIMEOUT_CYCLES=8, src_valid held 0 in LOAD -> error=1 and IDLE after 8 cycles; without the macro, still busy after 1000 cycles.

Source files
------------

// File: rtl/omsp_spm_key_loader.sv
// Loads KEY_WORDS 16-bit key words from a streaming source into one protected module.
// Optional stall timeout in LOAD is enabled by defining SPM_KEY_TIMEOUT_EN.
module omsp_spm_key_loader #(
  parameter int KEY_WORDS      = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        mclk,
  input  logic        puc_rst_n,
  input  logic        start,
  input  logic [15:0] start_id,
  input  logic        abort,
  input  logic        key_select_valid,
  input  logic        src_valid,
  input  logic [15:0] src_data,
  output logic        src_ready,
  output logic [15:0] spm_key_select,
  output logic        write_key,
  output logic [15:0] key_in,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int CW = $clog2(KEY_WORDS) + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_FLUSH = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]    state;
  logic [15:0]   sel_id;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          last_word;
  logic          stall_hit;

  // abort wins over a same-cycle acceptance, so the word never reaches the array
  assign accept    = (state == S_LOAD) && src_valid && !abort;
  assign last_word = (cnt == CW'(KEY_WORDS - 1));

  assign src_ready      = (state == S_LOAD);
  assign busy           = (state != S_IDLE);
  assign done           = (state == S_DONE) && !abort;
  assign spm_key_select = (state == S_IDLE) ? 16'h0 : sel_id;

`ifdef SPM_KEY_TIMEOUT_EN
  logic [7:0] stall;

  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n)                      stall <= 8'd0;
    else if (state != S_LOAD || accept)  stall <= 8'd0;
    else                                 stall <= stall + 8'd1;
  end

  assign stall_hit = !accept && (stall == 8'(TIMEOUT_CYCLES - 1));
`else
  // no stall limit: a negative cycle count is impossible, so this is constant false
  assign stall_hit = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      state     <= S_IDLE;
      sel_id    <= 16'h0;
      cnt       <= '0;
      write_key <= 1'b0;
      key_in    <= 16'h0;
      error     <= 1'b0;
    end else begin
      write_key <= accept;
      if (accept) key_in <= src_data;
      if (state == S_IDLE) begin
        if (start) begin
          if (start_id != 16'h0) begin
            sel_id <= start_id;
            error  <= 1'b0;
            cnt    <= '0;
            state  <= S_CHECK;
          end else begin
            error  <= 1'b1;
          end
        end
      end else if (abort) begin
        state <= S_IDLE;
        error <= 1'b1;
      end else begin
        case (state)
          S_CHECK: begin
            if (key_select_valid) state <= S_LOAD;
            else begin
              state <= S_IDLE;
              error <= 1'b1;
            end
          end
          S_LOAD: begin
            if (accept) begin
              cnt <= cnt + CW'(1);
              if (last_word) state <= S_FLUSH;
            end else if (stall_hit) begin
              state <= S_IDLE;
              error <= 1'b1;
            end
          end
          S_FLUSH: state <= S_DONE;
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
